// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU sequencer: operation codes and FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } ser_state_e;

    // Majority of three inputs; the carry function of a full adder.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/alu_fa_bit.sv
// One-bit full adder slice: supplies the ADD data bit for mux4 and the next carry.
module alu_fa_bit
    import alu_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Pure combinational sum/carry.
    assign sum  = a ^ b ^ cin;
    assign cout = maj3(a, b, cin);

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer wrapped around an external combinational mux4.
// Accepts a WIDTH-bit request, presents one bit slice per cycle to mux4,
// collects mux4's output into a shift register and returns the result.
//
// state  | meaning
// S_IDLE | ready for a request (in_ready=1)
// S_RUN  | streaming bit slices LSB first, one per clock
// S_DONE | result valid, held until out_ready
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             mux_d0,
    output logic             mux_d1,
    output logic             mux_d2,
    output logic             mux_d3,
    output logic [1:0]       mux_sel,
    input  logic             mux_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_e       state;
    alu_op_e          op_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic             run;
    logic             fa_sum;
    logic             fa_cout;
    logic             c_next;

    alu_fa_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Data bits for mux4 come straight from registered state and are zero outside RUN.
    assign run     = (state == S_RUN);
    assign mux_d0  = run & (a_sh[0] & b_sh[0]);
    assign mux_d1  = run & (a_sh[0] | b_sh[0]);
    assign mux_d2  = run & (a_sh[0] ^ b_sh[0]);
    assign mux_d3  = run & fa_sum;
    assign mux_sel = op_q;

    // Carry only propagates for ADD; logic ops keep it cleared so carry_out ends at 0.
    assign c_next  = (op_q == OP_ADD) ? fa_cout : 1'b0;

    // Sequencer FSM with all datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= OP_AND;
            a_sh      <= '0;
            b_sh      <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        op_q     <= alu_op_e'(op);
                        c        <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    result <= {mux_z, result[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    c      <= c_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        carry_out <= c_next;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl with a behavioural mux4 closing the loop.
module tb_alu_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       mux_d0, mux_d1, mux_d2, mux_d3;
    logic [1:0] mux_sel;
    logic       mux_z;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry_out;

    int n_cmp = 0;
    int n_err = 0;

    alu_serial_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .mux_d0    (mux_d0),
        .mux_d1    (mux_d1),
        .mux_d2    (mux_d2),
        .mux_d3    (mux_d3),
        .mux_sel   (mux_sel),
        .mux_z     (mux_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out)
    );

    // External mux4 harness
    assign mux_z = (mux_sel == 2'd0) ? mux_d0 :
                   (mux_sel == 2'd1) ? mux_d1 :
                   (mux_sel == 2'd2) ? mux_d2 : mux_d3;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input string tag, input logic [1:0] o,
                          input logic [7:0] ta, input logic [7:0] tb_v);
        int waited = 0;
        while (!in_ready && waited < 30) begin
            tick();
            waited++;
        end
        chk({tag, "_ready_wait"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op = o;
        a  = ta;
        b  = tb_v;
        tick();
        in_valid = 1'b0;
        chk({tag, "_in_ready_run"}, {31'b0, in_ready}, 32'd0);
        chk({tag, "_mux_sel"}, {30'b0, mux_sel}, {30'b0, o});
    endtask

    // Eight RUN cycles; mux data bits checked against a bench-side bit model.
    task automatic run_bits(input string tag, input logic [1:0] o,
                            input logic [7:0] ta, input logic [7:0] tb_v);
        logic cm = 1'b0;
        logic [3:0] exp_d;
        for (int i = 0; i < 8; i++) begin
            exp_d[0] = ta[i] & tb_v[i];
            exp_d[1] = ta[i] | tb_v[i];
            exp_d[2] = ta[i] ^ tb_v[i];
            exp_d[3] = ta[i] ^ tb_v[i] ^ cm;
            chk($sformatf("%s_mux_d_bit%0d", tag, i),
                {28'b0, mux_d3, mux_d2, mux_d1, mux_d0}, {28'b0, exp_d});
            chk($sformatf("%s_out_valid_low_bit%0d", tag, i), {31'b0, out_valid}, 32'd0);
            chk($sformatf("%s_sel_bit%0d", tag, i), {30'b0, mux_sel}, {30'b0, o});
            if (o == 2'b11)
                cm = (ta[i] & tb_v[i]) | (ta[i] & cm) | (tb_v[i] & cm);
            tick();
        end
    endtask

    task automatic check_done(input string tag, input logic [7:0] er, input logic ec);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_result"}, {24'b0, result}, {24'b0, er});
        chk({tag, "_carry_out"}, {31'b0, carry_out}, {31'b0, ec});
        chk({tag, "_in_ready_done"}, {31'b0, in_ready}, 32'd0);
        chk({tag, "_mux_d_done"}, {28'b0, mux_d3, mux_d2, mux_d1, mux_d0}, 32'd0);
    endtask

    task automatic handshake(input string tag, input logic [7:0] er);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_in_ready_idle"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_result_hold"}, {24'b0, result}, {24'b0, er});
        chk({tag, "_mux_d_idle"}, {28'b0, mux_d3, mux_d2, mux_d1, mux_d0}, 32'd0);
    endtask

    task automatic full_op(input string tag, input logic [1:0] o, input logic [7:0] ta,
                           input logic [7:0] tb_v, input logic [7:0] er, input logic ec);
        accept(tag, o, ta, tb_v);
        run_bits(tag, o, ta, tb_v);
        check_done(tag, er, ec);
        handshake(tag, er);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 2'b00;
        a         = 8'h00;
        b         = 8'h00;
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", {24'b0, result}, 32'd0);
        chk("rst_carry_out", {31'b0, carry_out}, 32'd0);
        chk("rst_mux_sel", {30'b0, mux_sel}, 32'd0);
        chk("rst_mux_d", {28'b0, mux_d3, mux_d2, mux_d1, mux_d0}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: AND, latency checked by run_bits (low through 8 RUN cycles) then check_done
        full_op("and_f0_3c", 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0);

        // 2: ADD with and without overflow
        full_op("add_ff_01", 2'b11, 8'hFF, 8'h01, 8'h00, 1'b1);
        full_op("add_25_1a", 2'b11, 8'h25, 8'h1A, 8'h3F, 1'b0);

        // 3: XOR with 5 stalled cycles in DONE
        accept("xor_aa_ff", 2'b10, 8'hAA, 8'hFF);
        run_bits("xor_aa_ff", 2'b10, 8'hAA, 8'hFF);
        check_done("xor_aa_ff", 8'h55, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("xor_stall%0d_out_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("xor_stall%0d_result", i), {24'b0, result}, 32'h55);
            chk($sformatf("xor_stall%0d_in_ready", i), {31'b0, in_ready}, 32'd0);
        end
        handshake("xor_aa_ff", 8'h55);

        // 4: reset after the 3rd RUN edge of an OR request
        accept("or_rst", 2'b01, 8'h12, 8'h40);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_mux_d", {28'b0, mux_d3, mux_d2, mux_d1, mux_d0}, 32'd0);
        chk("midrst_result", {24'b0, result}, 32'd0);
        chk("midrst_mux_sel", {30'b0, mux_sel}, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        full_op("add_01_01", 2'b11, 8'h01, 8'h01, 8'h02, 1'b0);

        // 5: in_valid held high with a queued second request
        accept("q_and", 2'b00, 8'h0F, 8'hFF);
        in_valid = 1'b1;
        op = 2'b01;
        a  = 8'h0F;
        b  = 8'hF0;
        run_bits("q_and", 2'b00, 8'h0F, 8'hFF);
        check_done("q_and", 8'h0F, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("q_hs_in_ready", {31'b0, in_ready}, 32'd1);
        chk("q_hs_out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("q_second_accept", {31'b0, in_ready}, 32'd0);
        chk("q_second_sel", {30'b0, mux_sel}, 32'd1);
        run_bits("q_or", 2'b01, 8'h0F, 8'hF0);
        check_done("q_or", 8'hFF, 1'b0);
        handshake("q_or", 8'hFF);

        // Extra ADD overflow where both MSBs carry out
        full_op("add_80_80", 2'b11, 8'h80, 8'h80, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
